// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32I load/store sequencer between execute stage and memory arbiter.
//   clk, rst                  : clock and asynchronous active-high reset
//   i_valid/o_ready           : core request handshake (o_ready only in IDLE)
//   i_ld, i_str, i_funct3     : request type and RV32I width/sign field
//   i_addr, i_wdata           : byte address and store operand
//   o_ld, o_str               : memory strobes, asserted only in ACCESS
//   o_addr, o_wdata, o_wmask  : word-aligned address, lane-replicated data, byte enables
//   i_mem_ack, i_rdata        : memory completion and raw read word
//   o_rvalid, o_rdata         : extended load result pulse / held value
//   o_done, o_misalign        : completion pulse / rejected-request pulse
//   o_timeout, o_stall        : aborted-access pulse / core stall
module lsu_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_ld,
    input  logic        i_str,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_ld,
    output logic        o_str,
    output logic [31:0] o_addr,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_wmask,
    input  logic        i_mem_ack,
    input  logic [31:0] i_rdata,
    output logic        o_rvalid,
    output logic [31:0] o_rdata,
    output logic        o_done,
    output logic        o_misalign,
    output logic        o_timeout,
    output logic        o_stall
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE, S_ERR} state_t;

    state_t      r_state, w_next;
    logic        r_ld;
    logic        r_to;
    logic [2:0]  r_f3;
    logic [1:0]  r_off;
    logic [7:0]  r_cnt;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [3:0]  r_wmask;

    logic        w_accept, w_legal, w_aligned, w_ok, w_ack, w_expire;
    logic [31:0] w_st_data, w_ext;
    logic [3:0]  w_st_mask;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // a request with both type bits set is treated as a store
    assign w_accept  = (r_state == S_IDLE) && i_valid && (i_ld || i_str);
    assign w_legal   = i_str ? (!i_funct3[2] && i_funct3[1:0] != 2'b11)
                             : (i_funct3[1:0] != 2'b11 && i_funct3 != 3'b110);
    assign w_aligned = (i_funct3[1:0] == 2'b01) ? !i_addr[0] :
                       (i_funct3[1:0] == 2'b10) ? (i_addr[1:0] == 2'b00) : 1'b1;
    assign w_ok      = w_legal && w_aligned;

    assign w_st_data = (i_funct3[1:0] == 2'b00) ? {4{i_wdata[7:0]}} :
                       (i_funct3[1:0] == 2'b01) ? {2{i_wdata[15:0]}} : i_wdata;
    assign w_st_mask = (i_funct3[1:0] == 2'b00) ? (4'b0001 << i_addr[1:0]) :
                       (i_funct3[1:0] == 2'b01) ? (4'b0011 << {i_addr[1], 1'b0}) : 4'b1111;

    // extraction uses the offset and funct3 latched at accept
    assign w_byte = i_rdata[{r_off, 3'b000} +: 8];
    assign w_half = r_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    assign w_ext  = (r_f3[1:0] == 2'b00) ? {{24{!r_f3[2] && w_byte[7]}}, w_byte} :
                    (r_f3[1:0] == 2'b01) ? {{16{!r_f3[2] && w_half[15]}}, w_half} : i_rdata;

    assign w_ack    = (r_state == S_ACCESS) && i_mem_ack;
    assign w_expire = (r_cnt == 8'(TIMEOUT - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = w_accept ? (w_ok ? S_ACCESS : S_ERR) : S_IDLE;
            S_ACCESS: w_next = i_mem_ack ? S_DONE : (w_expire ? S_ERR : S_ACCESS);
            S_DONE:   w_next = S_IDLE;
            S_ERR:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ld    <= 1'b0;
            r_to    <= 1'b0;
            r_f3    <= 3'b000;
            r_off   <= 2'b00;
            r_cnt   <= 8'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_wmask <= 4'd0;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == S_ACCESS) ? r_cnt + 8'd1 : 8'd0;
            if (w_accept) begin
                r_ld    <= !i_str;
                r_to    <= 1'b0;
                r_f3    <= i_funct3;
                r_off   <= i_addr[1:0];
                r_addr  <= {i_addr[31:2], 2'b00};
                r_wdata <= i_str ? w_st_data : i_wdata;
                r_wmask <= i_str ? w_st_mask : 4'd0;
            end
            // distinguishes a timeout abort from a rejected request in ERR
            if (r_state == S_ACCESS && !i_mem_ack && w_expire)
                r_to <= 1'b1;
            if (w_ack && r_ld)
                r_rdata <= w_ext;
        end
    end

    assign o_ready    = (r_state == S_IDLE);
    assign o_ld       = (r_state == S_ACCESS) && r_ld;
    assign o_str      = (r_state == S_ACCESS) && !r_ld;
    assign o_addr     = r_addr;
    assign o_wdata    = r_wdata;
    assign o_wmask    = r_wmask;
    assign o_rdata    = r_rdata;
    assign o_done     = (r_state == S_DONE);
    assign o_rvalid   = (r_state == S_DONE) && r_ld;
    assign o_misalign = (r_state == S_ERR) && !r_to;
    assign o_timeout  = (r_state == S_ERR) && r_to;
    assign o_stall    = w_accept || (r_state == S_ACCESS) || (r_state == S_DONE);
endmodule
